// File: rtl/tlu_ch_tx_pkg.sv
// Shared constants, state encoding and slot-arithmetic helpers for the TLU
// channel transmitter.
package tlu_ch_tx_pkg;

  localparam int SLOTS  = 16;  // slots per CLK40 cycle
  localparam int SLOT_W = 4;   // slot index width
  localparam int END_W  = 9;   // end-slot width, max 15 + 255 = 270
  localparam int CYC_W  = 5;   // pulse-relative cycle counter width

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP
  } state_e;

  // Exclusive end slot of a pulse: E = S + WIDTH.
  function automatic logic [END_W-1:0] slot_end(input logic [SLOT_W-1:0] s,
                                                input logic [7:0]        w);
    return END_W'(s) + END_W'(w);
  endfunction

  // Index of the last cycle carrying a high slot: (E-1) >> 4.
  function automatic logic [CYC_W-1:0] last_cycle(input logic [END_W-1:0] e);
    return CYC_W'((e - END_W'(1)) >> SLOT_W);
  endfunction

endpackage

// File: rtl/tlu_ch_tx_word.sv
// Combinational mask generator: slot j of cycle c is high iff S <= 16c+j < E.
// Slot 0 (earliest in time) lands on word bit 15.
module tlu_ch_tx_word
  import tlu_ch_tx_pkg::*;
(
  input  logic [SLOT_W-1:0] s,
  input  logic [END_W-1:0]  e,
  input  logic [CYC_W-1:0]  c,
  output logic [SLOTS-1:0]  word
);

  logic [END_W-1:0] slot_idx;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it holding its old value and a latch cannot be inferred.
  always_comb begin
    word     = '0;
    slot_idx = '0;
    for (int j = 0; j < SLOTS; j++) begin
      slot_idx          = {c, SLOT_W'(j)};
      word[SLOTS-1-j]   = (slot_idx >= END_W'(s)) && (slot_idx < e);
    end
  end

endmodule

// File: rtl/tlu_ch_tx.sv
// TLU channel pulse-train transmitter: one 16-slot word per CLK40 cycle.
// Define TLU_CH_TX_TIMESTAMP_EN to add TIME_STAMP / LAST_START readback.
module tlu_ch_tx
  import tlu_ch_tx_pkg::*;
#(
  parameter int MAX_PULSES = 255
) (
  input  logic        CLK40,
  input  logic        RST_N,
  input  logic        EN,
  input  logic        EN_INVERT,
  input  logic        START,
  input  logic [3:0]  FINE_DELAY,
  input  logic [7:0]  WIDTH,
  input  logic [7:0]  NUM_PULSES,
  input  logic [7:0]  PERIOD,
  output logic        READY,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] OUT
`ifdef TLU_CH_TX_TIMESTAMP_EN
  ,
  input  logic [3:0]  TIME_STAMP,
  output logic [7:0]  LAST_START
`endif
);

  state_e             state_q, state_d;
  logic [SLOT_W-1:0]  s_q, s_d;
  logic [END_W-1:0]   e_q, e_d;
  logic [7:0]         n_q, n_d;        // pulses left, including the current one
  logic [7:0]         period_q, period_d;
  logic [7:0]         pos_q, pos_d;    // cycles since the current pulse's c=0
  logic [SLOTS-1:0]   out_q, out_d;
  logic               done_q, done_d;

  logic               accept;
  logic [CYC_W-1:0]   c_last;
  logic [END_W-1:0]   e_new;
  logic [7:0]         span_new;
  logic [7:0]         n_new;
  logic [SLOTS-1:0]   word;
  logic [SLOTS-1:0]   out_raw;

  assign accept   = START && EN && (state_q == IDLE) &&
                    (WIDTH != '0) && (NUM_PULSES != '0);
  assign c_last   = last_cycle(e_q);
  assign e_new    = slot_end(FINE_DELAY, WIDTH);
  assign span_new = 8'(last_cycle(e_new)) + 8'd1;
  assign n_new    = (int'(NUM_PULSES) > MAX_PULSES) ? 8'(MAX_PULSES) : NUM_PULSES;

  tlu_ch_tx_word u_word (
    .s    (s_q),
    .e    (e_q),
    .c    (pos_q[CYC_W-1:0]),
    .word (word)
  );

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    e_d      = e_q;
    n_d      = n_q;
    period_d = period_q;
    pos_d    = pos_q;
    done_d   = 1'b0;
    out_raw  = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = PULSE;
          s_d      = FINE_DELAY;
          e_d      = e_new;
          n_d      = n_new;
          // Stretch the period so consecutive pulses never overlap.
          period_d = (PERIOD > span_new) ? PERIOD : span_new;
          pos_d    = '0;
        end
      end

      PULSE: begin
        out_raw = word;
        pos_d   = pos_q + 8'd1;
        if (pos_q == 8'(c_last)) begin
          if (EN && (n_q > 8'd1)) begin
            n_d = n_q - 8'd1;
            if (period_q == 8'(c_last) + 8'd1) begin
              pos_d = '0;
            end else begin
              state_d = GAP;
            end
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      GAP: begin
        pos_d = pos_q + 8'd1;
        if (!EN) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (pos_q == period_q - 8'd1) begin
          state_d = PULSE;
          pos_d   = '0;
        end
      end

      default: state_d = IDLE;
    endcase

    // Polarity is applied to whatever word is registered next, never latched.
    out_d = out_raw ^ {SLOTS{EN_INVERT}};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      s_q      <= '0;
      e_q      <= '0;
      n_q      <= '0;
      period_q <= '0;
      pos_q    <= '0;
      out_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      e_q      <= e_d;
      n_q      <= n_d;
      period_q <= period_d;
      pos_q    <= pos_d;
      out_q    <= out_d;
      done_q   <= done_d;
    end
  end

  assign READY = (state_q == IDLE);
  assign BUSY  = (state_q != IDLE);
  assign DONE  = done_q;
  assign OUT   = out_q;

`ifdef TLU_CH_TX_TIMESTAMP_EN
  logic [7:0] last_start_q, last_start_d;

  always_comb begin
    last_start_d = last_start_q;
    if ((state_q == PULSE) && (pos_q == '0)) begin
      last_start_d = {TIME_STAMP, s_q};
    end
  end

  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      last_start_q <= '0;
    end else begin
      last_start_q <= last_start_d;
    end
  end

  assign LAST_START = last_start_q;
`endif

endmodule

// File: tb/tb_tlu_ch_tx.sv
// Scoreboard bench for tlu_ch_tx (default build): expected words are queued
// when a train is requested and compared on every falling edge.
module tb_tlu_ch_tx;

  logic        CLK40;
  logic        RST_N;
  logic        EN;
  logic        EN_INVERT;
  logic        START;
  logic [3:0]  FINE_DELAY;
  logic [7:0]  WIDTH;
  logic [7:0]  NUM_PULSES;
  logic [7:0]  PERIOD;
  logic        READY;
  logic        BUSY;
  logic        DONE;
  logic [15:0] OUT;

  typedef struct {
    logic [15:0] word;
    logic        done;
  } exp_t;

  exp_t sb_q[$];
  exp_t ent;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 0;

  tlu_ch_tx dut (
    .CLK40      (CLK40),
    .RST_N      (RST_N),
    .EN         (EN),
    .EN_INVERT  (EN_INVERT),
    .START      (START),
    .FINE_DELAY (FINE_DELAY),
    .WIDTH      (WIDTH),
    .NUM_PULSES (NUM_PULSES),
    .PERIOD     (PERIOD),
    .READY      (READY),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .OUT        (OUT)
  );

  initial CLK40 = 1'b0;
  always #5 CLK40 = ~CLK40;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected word stream: one idle word for the accepting edge, then every
  // pulse laid out on a slot timeline and cut into 16-slot words.
  task automatic push_train(input int fine, input int width, input int n,
                            input int period, input logic inv);
    int          e, clast, pe;
    bit          line[0:287];
    logic [15:0] w;
    logic [15:0] idle;
    exp_t        x;
    idle  = inv ? 16'hFFFF : 16'h0000;
    e     = fine + width;
    clast = (e - 1) / 16;
    pe    = (period > clast + 1) ? period : clast + 1;
    for (int t = 0; t < 288; t++) line[t] = (t >= fine) && (t < e);
    x.word = idle;
    x.done = 1'b0;
    sb_q.push_back(x);
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < pe; c++) begin
        if ((p == n - 1) && (c > clast)) break;
        w = 16'h0000;
        if (c <= clast) begin
          for (int j = 0; j < 16; j++) w[15-j] = line[16*c + j];
        end
        x.word = w ^ idle;
        x.done = (p == n - 1) && (c == clast);
        sb_q.push_back(x);
      end
    end
  endtask

  // Called just after a falling edge; START is sampled on the next rising edge.
  task automatic drive_start(input int fine, input int width, input int n, input int period);
    FINE_DELAY = 4'(fine);
    WIDTH      = 8'(width);
    NUM_PULSES = 8'(n);
    PERIOD     = 8'(period);
    START      = 1'b1;
    @(negedge CLK40); #1;
    START      = 1'b0;
  endtask

  task automatic start_train(input int fine, input int width, input int n,
                             input int period, input int n_model);
    push_train(fine, width, n_model, period, EN_INVERT);
    drive_start(fine, width, n, period);
  endtask

  task automatic wait_drain();
    int cnt;
    cnt = 0;
    while ((sb_q.size() != 0) && (cnt < 3000)) begin
      @(negedge CLK40); #1;
      cnt++;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge CLK40); #1;
    end
  endtask

  always @(negedge CLK40) begin
    if (mon_en) begin
      if (sb_q.size() != 0) begin
        ent = sb_q.pop_front();
        check("out", OUT, ent.word);
        check("done", DONE, ent.done);
        check("ready", READY, sb_q.size() == 0);
        check("busy", BUSY, sb_q.size() != 0);
      end else begin
        check("idle_out", OUT, EN_INVERT ? 16'hFFFF : 16'h0000);
        check("idle_done", DONE, 0);
        check("idle_ready", READY, 1);
        check("idle_busy", BUSY, 0);
      end
    end
  end

  initial begin
    int f, w, n, p;
    RST_N = 1'b0; EN = 1'b0; EN_INVERT = 1'b0; START = 1'b0;
    FINE_DELAY = '0; WIDTH = '0; NUM_PULSES = '0; PERIOD = '0;
    #1;
    check("rst_out", OUT, 16'h0000);
    check("rst_done", DONE, 0);
    check("rst_ready", READY, 1);
    check("rst_busy", BUSY, 0);
    @(negedge CLK40); #1;
    RST_N  = 1'b1;
    EN     = 1'b1;
    mon_en = 1;
    idle_cycles(2);

    // Single pulses at several placements, including a cycle-straddling one.
    start_train(0, 16, 1, 0, 1);  wait_drain();
    start_train(4, 8, 1, 0, 1);   wait_drain();
    start_train(12, 8, 1, 0, 1);  wait_drain();

    // Train of three; a START mid-train with other parameters must be ignored.
    start_train(0, 4, 3, 5, 3);
    idle_cycles(1);
    drive_start(7, 20, 9, 2);
    wait_drain();

    // Period shorter than the pulse is stretched to back-to-back pulses.
    start_train(0, 40, 2, 1, 2);  wait_drain();

    // Back-to-back trains: second START right in the DONE cycle.
    start_train(4, 8, 2, 2, 2);   wait_drain();
    start_train(12, 8, 1, 0, 1);  wait_drain();

    // Inverted polarity, then requests that must be dropped.
    EN_INVERT = 1'b1;
    idle_cycles(2);
    start_train(4, 8, 1, 0, 1);   wait_drain();
    drive_start(3, 0, 2, 4);
    drive_start(3, 10, 0, 4);
    EN = 1'b0;
    drive_start(3, 10, 2, 4);
    EN = 1'b1;
    idle_cycles(3);
    EN_INVERT = 1'b0;
    idle_cycles(2);

    // EN falls during pulse 1 of 4: that pulse finishes, then DONE.
    start_train(0, 40, 4, 6, 1);
    idle_cycles(1);
    EN = 1'b0;
    wait_drain();
    idle_cycles(4);
    EN = 1'b1;
    idle_cycles(1);

    // Reset in the middle of the second word of a 3-word pulse.
    start_train(0, 40, 1, 0, 1);
    repeat (2) @(posedge CLK40);
    #1;
    check("pre_rst_word", OUT, 16'hFFFF);
    mon_en = 0;
    RST_N  = 1'b0;
    #1;
    check("abort_out", OUT, 16'h0000);
    check("abort_ready", READY, 1);
    check("abort_done", DONE, 0);
    sb_q.delete();
    EN_INVERT = 1'b1;
    @(negedge CLK40); #1;
    RST_N  = 1'b1;
    mon_en = 1;
    idle_cycles(2);
    EN_INVERT = 1'b0;
    idle_cycles(1);

    // Random trains with random polarity.
    for (int i = 0; i < 8; i++) begin
      f = $urandom_range(15, 0);
      w = $urandom_range(255, 1);
      n = $urandom_range(4, 1);
      p = $urandom_range(20, 0);
      EN_INVERT = 1'($urandom_range(1, 0));
      idle_cycles(1);
      start_train(f, w, n, p, n);
      wait_drain();
    end
    EN_INVERT = 1'b0;
    idle_cycles(3);

    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
